pong_core_2p: RTL and testbench

- Parametrised two-player successor of the single-paddle pixel/game block.
- Holds both paddles, ball position/velocity, per-player scores and a serve/play/point/game-over state machine, all updated once per frame.
- Produces the per-pixel rgb for the VGA pipeline; score outputs feed the seven-segment display driver.

---
 rtl/pong_core_2p.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_pong_core_2p.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_core_2p.sv
// Two-player pong core: paddles, ball, scores and match FSM advanced once per frame,
// plus the combinational per-pixel colour for the VGA pipeline.
module pong_core_2p #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PAD_H        = 96,
    parameter int PAD_W        = 4,
    parameter int PAD_L_X      = 16,
    parameter int PAD_R_X      = 620,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_STEP     = 2,
    parameter int BALL_V0      = 2,
    parameter int BALL_VMAX    = 7,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  up,
    input  logic [1:0]  down,
    input  logic        start,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [11:0] rgb,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  state,
    output logic        winner
);

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0] BX0     = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BY0     = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PAD0    = 10'((V_ACTIVE - PAD_H) / 2);
    localparam logic [9:0] PAD_MAX = 10'(V_ACTIVE - PAD_H);
    localparam logic [9:0] STEP    = 10'(PAD_STEP);
    localparam logic [9:0] BS1     = 10'(BALL_SIZE - 1);
    localparam logic [9:0] PH1     = 10'(PAD_H - 1);
    localparam logic [9:0] LX0     = 10'(PAD_L_X);
    localparam logic [9:0] LX1     = 10'(PAD_L_X + PAD_W - 1);
    localparam logic [9:0] RX0     = 10'(PAD_R_X);
    localparam logic [9:0] RX1     = 10'(PAD_R_X + PAD_W - 1);
    localparam logic [9:0] XMAX    = 10'(H_ACTIVE - 1);
    localparam logic [9:0] YMAX    = 10'(V_ACTIVE - 1);
    localparam logic [9:0] NET_X   = 10'(H_ACTIVE / 2);
    localparam logic [9:0] Y_TICK  = 10'(V_ACTIVE + 1);
    localparam logic [4:0] VMAX    = 5'(BALL_VMAX);
    localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);
    localparam logic [CW-1:0] SF1  = CW'(SERVE_FRAMES - 1);

    localparam logic signed [4:0] V_POS = 5'(BALL_V0);
    localparam logic signed [4:0] V_NEG = -V_POS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         score_l_q, score_l_d;
    logic [3:0]         score_r_q, score_r_d;
    logic               winner_q, winner_d;
    logic               scorer_q, scorer_d;
    logic               serve_r_q, serve_r_d;
    logic [9:0]         bx_q, bx_d;
    logic [9:0]         by_q, by_d;
    logic signed [4:0]  dx_q, dx_d;
    logic signed [4:0]  dy_q, dy_d;
    logic [9:0]         pad_l_q, pad_l_d;
    logic [9:0]         pad_r_q, pad_r_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic       frame_tick;
    logic [4:0] adx5, ady5, vmag;
    logic [9:0] adx, ady, bx_r, by_b;
    logic       dx_neg, dx_pos, dy_neg, dy_pos;
    logic       hit_l, hit_r, miss_l, miss_r;
    logic [3:0] sc_new;

    function automatic logic [9:0] pad_next(input logic [9:0] top,
                                            input logic       u,
                                            input logic       d);
        logic [9:0] res;
        res = top;
        if (u) begin
            res = (top < STEP) ? 10'd0 : top - STEP;
        end else if (d) begin
            res = (top > PAD_MAX - STEP) ? PAD_MAX : top + STEP;
        end
        return res;
    endfunction

    function automatic logic overlap(input logic [9:0] b, input logic [9:0] t);
        return (b <= t + PH1) && (t <= b + BS1);
    endfunction

    assign frame_tick = (y == Y_TICK) && (x == 10'd0);

    assign dx_neg = dx_q[4];
    assign dx_pos = !dx_q[4] && (dx_q != 5'sd0);
    assign dy_neg = dy_q[4];
    assign dy_pos = !dy_q[4] && (dy_q != 5'sd0);
    assign adx5   = dx_neg ? 5'(-dx_q) : 5'(dx_q);
    assign ady5   = dy_neg ? 5'(-dy_q) : 5'(dy_q);
    assign adx    = {5'd0, adx5};
    assign ady    = {5'd0, ady5};
    assign vmag   = (adx5 >= VMAX) ? VMAX : adx5 + 5'd1;
    assign bx_r   = bx_q + BS1;
    assign by_b   = by_q + BS1;

    // Hit windows widen by |dx| so a fast ball cannot tunnel through a paddle
    assign hit_l  = dx_neg && (bx_q >= LX0) && (bx_q <= LX1 + adx)
                    && overlap(by_q, pad_l_q);
    assign hit_r  = dx_pos && (bx_r >= RX0 - adx) && (bx_r <= RX1)
                    && overlap(by_q, pad_r_q);
    assign miss_l = dx_neg && (bx_q <= adx);
    assign miss_r = dx_pos && (bx_r >= XMAX - adx);

    assign sc_new = scorer_q ? score_r_q + 4'd1 : score_l_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        scorer_d  = scorer_q;
        serve_r_d = serve_r_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        pad_l_d   = pad_l_q;
        pad_r_d   = pad_r_q;
        cnt_d     = cnt_q;
        if (frame_tick) begin
            if (state_q != S_OVER) begin
                pad_l_d = pad_next(pad_l_q, up[0], down[0]);
                pad_r_d = pad_next(pad_r_q, up[1], down[1]);
            end
            unique case (state_q)
                S_IDLE: begin
                    bx_d = BX0;
                    by_d = BY0;
                    if (start) begin
                        state_d = S_SERVE;
                        cnt_d   = '0;
                    end
                end
                S_SERVE: begin
                    bx_d = BX0;
                    by_d = BY0;
                    if (cnt_q == SF1) begin
                        state_d = S_PLAY;
                        dx_d    = serve_r_q ? V_POS : V_NEG;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PLAY: begin
                    if (hit_l) begin
                        dx_d = vmag;
                    end else if (hit_r) begin
                        dx_d = -$signed(vmag);
                    end else if (miss_l) begin
                        scorer_d = 1'b1;
                        state_d  = S_POINT;
                    end else if (miss_r) begin
                        scorer_d = 1'b0;
                        state_d  = S_POINT;
                    end
                    if (dy_neg && (by_q <= ady)) begin
                        dy_d = V_POS;
                    end else if (dy_pos && (by_b >= YMAX - ady)) begin
                        dy_d = V_NEG;
                    end
                    if (!(miss_l || miss_r) || hit_l || hit_r) begin
                        bx_d = bx_q + {{5{dx_d[4]}}, dx_d};
                        by_d = by_q + {{5{dy_d[4]}}, dy_d};
                    end
                end
                S_POINT: begin
                    if (scorer_q) begin
                        score_r_d = sc_new;
                    end else begin
                        score_l_d = sc_new;
                    end
                    // The conceding player receives the next serve
                    serve_r_d = !scorer_q;
                    dx_d      = scorer_q ? V_NEG : V_POS;
                    bx_d      = BX0;
                    by_d      = BY0;
                    cnt_d     = '0;
                    if (sc_new == WIN_S) begin
                        state_d  = S_OVER;
                        winner_d = scorer_q;
                    end else begin
                        state_d = S_SERVE;
                    end
                end
                S_OVER: begin
                    bx_d = BX0;
                    by_d = BY0;
                    if (start) begin
                        score_l_d = 4'd0;
                        score_r_d = 4'd0;
                        serve_r_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_SERVE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            winner_q  <= 1'b0;
            scorer_q  <= 1'b0;
            serve_r_q <= 1'b1;
            bx_q      <= BX0;
            by_q      <= BY0;
            dx_q      <= V_POS;
            dy_q      <= V_POS;
            pad_l_q   <= PAD0;
            pad_r_q   <= PAD0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            scorer_q  <= scorer_d;
            serve_r_q <= serve_r_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            pad_l_q   <= pad_l_d;
            pad_r_q   <= pad_r_d;
            cnt_q     <= cnt_d;
        end
    end

    logic in_pad_l, in_pad_r, in_ball, in_net;

    assign in_pad_l = (x >= LX0) && (x <= LX1)
                      && (y >= pad_l_q) && (y <= pad_l_q + PH1);
    assign in_pad_r = (x >= RX0) && (x <= RX1)
                      && (y >= pad_r_q) && (y <= pad_r_q + PH1);
    assign in_ball  = (x >= bx_q) && (x <= bx_r)
                      && (y >= by_q) && (y <= by_b);
    assign in_net   = (x == NET_X) && !y[3];

    always_comb begin
        rgb = 12'hCCC;
        if (!video_on) begin
            rgb = 12'h000;
        end else if (in_pad_l || in_pad_r) begin
            rgb = 12'h111;
        end else if (in_ball) begin
            rgb = 12'h1FF;
        end else if (in_net) begin
            rgb = 12'h888;
        end
    end

    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign state   = state_q;
    assign winner  = winner_q;

endmodule

// File: tb/tb_pong_core_2p.sv
// Randomised bench for pong_core_2p against a frame-level game model;
// pixels around the ball and paddles are probed to observe hidden state.
module tb_pong_core_2p;

    localparam int H = 640, V = 480, PH = 96, PW = 4, LX = 16, RX = 620;
    localparam int BS = 8, STEP = 2, V0 = 2, VMAX = 7, WIN = 7, SF = 60;
    localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  up = 2'b00;
    logic [1:0]  down = 2'b00;
    logic        start = 1'b0;
    logic        video_on = 1'b1;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic [11:0] rgb;
    logic [3:0]  score_l, score_r;
    logic [2:0]  state;
    logic        winner;

    always #5 clk = ~clk;

    pong_core_2p dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .start(start),
        .video_on(video_on), .x(x), .y(y), .rgb(rgb),
        .score_l(score_l), .score_r(score_r), .state(state), .winner(winner)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Game model at frame granularity
    int gs, sl, sr, win, scorer, sdir, cnt;
    int bx, by, dx, dy, padl, padr;

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit ov(int bally, int top);
        return (bally <= top + PH - 1) && (top <= bally + BS - 1);
    endfunction

    function automatic int mv(int top, bit u, bit d);
        if (u) return (top - STEP < 0) ? 0 : top - STEP;
        if (d) return (top + STEP > V - PH) ? V - PH : top + STEP;
        return top;
    endfunction

    task automatic model_reset();
        gs = IDLE; sl = 0; sr = 0; win = 0; scorer = 0; sdir = 1; cnt = 0;
        bx = (H - BS) / 2; by = (V - BS) / 2; dx = V0; dy = V0;
        padl = (V - PH) / 2; padr = (V - PH) / 2;
    endtask

    task automatic model_tick(input logic [1:0] u, input logic [1:0] d,
                              input logic st);
        int nl, nr, ax, ay, pts;
        bit scored;
        nl = padl; nr = padr;
        if (gs != OVER) begin
            nl = mv(padl, u[0], d[0]);
            nr = mv(padr, u[1], d[1]);
        end
        case (gs)
            IDLE: if (st) begin gs = SERVE; cnt = 0; end
            SERVE: begin
                if (cnt == SF - 1) begin gs = PLAY; dx = sdir * V0; end
                else cnt++;
            end
            PLAY: begin
                ax = iabs(dx); ay = iabs(dy); scored = 0;
                if (dx < 0 && bx >= LX && bx <= LX + PW - 1 + ax && ov(by, padl))
                    dx = imin(ax + 1, VMAX);
                else if (dx > 0 && bx + BS - 1 >= RX - ax
                         && bx + BS - 1 <= RX + PW - 1 && ov(by, padr))
                    dx = -imin(ax + 1, VMAX);
                else if (dx < 0 && bx <= ax) begin scorer = 1; scored = 1; end
                else if (dx > 0 && bx + BS - 1 >= H - 1 - ax) begin
                    scorer = 0; scored = 1;
                end
                if (dy < 0 && by <= ay) dy = V0;
                else if (dy > 0 && by + BS - 1 >= V - 1 - ay) dy = -V0;
                if (scored) gs = POINT;
                else begin bx += dx; by += dy; end
            end
            POINT: begin
                if (scorer == 1) sr++; else sl++;
                pts = (scorer == 1) ? sr : sl;
                sdir = (scorer == 1) ? -1 : 1;
                bx = (H - BS) / 2; by = (V - BS) / 2; dx = sdir * V0; cnt = 0;
                if (pts == WIN) begin gs = OVER; win = scorer; end
                else gs = SERVE;
            end
            OVER: if (st) begin sl = 0; sr = 0; sdir = 1; cnt = 0; gs = SERVE; end
            default: gs = IDLE;
        endcase
        padl = nl; padr = nr;
    endtask

    function automatic int m_rgb(int px, int py, bit von);
        if (!von) return 'h000;
        if (px >= LX && px <= LX + PW - 1 && py >= padl && py <= padl + PH - 1)
            return 'h111;
        if (px >= RX && px <= RX + PW - 1 && py >= padr && py <= padr + PH - 1)
            return 'h111;
        if (px >= bx && px < bx + BS && py >= by && py < by + BS) return 'h1FF;
        if (px == H / 2 && ((py / 8) % 2) == 0) return 'h888;
        return 'hCCC;
    endfunction

    task automatic probe(input int px, input int py, input bit von,
                         input string tag);
        if (px < 0 || px >= H || py < 0 || py >= V) return;
        x = 10'(px); y = 10'(py); video_on = von;
        #1;
        check(tag, 32'(rgb), m_rgb(px, py, von));
    endtask

    task automatic check_regs();
        check("state", 32'(state), gs);
        check("score_l", 32'(score_l), sl);
        check("score_r", 32'(score_r), sr);
        check("winner", 32'(winner), win);
    endtask

    task automatic probes();
        probe(bx, by, 1'b1, "ball_tl");
        probe(bx + BS - 1, by + BS - 1, 1'b1, "ball_br");
        probe(bx - 1, by, 1'b1, "ball_west");
        probe(bx + BS, by + BS - 1, 1'b1, "ball_east");
        probe(LX, padl, 1'b1, "padl_top");
        probe(LX + PW - 1, padl - 1, 1'b1, "padl_above");
        probe(RX + PW - 1, padr + PH - 1, 1'b1, "padr_bot");
        probe(RX, padr + PH, 1'b1, "padr_below");
        probe($urandom_range(0, H - 1), $urandom_range(0, V - 1),
              ($urandom_range(0, 9) != 0), "pix_rand");
        video_on = 1'b1;
    endtask

    task automatic frame(input logic [1:0] u, input logic [1:0] d,
                         input logic st);
        @(negedge clk);
        up = u; down = d; start = st;
        x = 10'd0; y = 10'(V + 1);
        @(posedge clk);
        model_tick(u, d, st);
        #1;
        x = 10'd1; y = 10'd0;
        check_regs();
        probes();
    endtask

    task automatic do_reset(input bit on_tick);
        @(negedge clk);
        reset = 1'b1;
        up = 2'($urandom); down = 2'($urandom); start = 1'($urandom);
        if (on_tick) begin x = 10'd0; y = 10'(V + 1); end
        else begin x = 10'd5; y = 10'd7; end
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        x = 10'd1; y = 10'd0;
        check_regs();
        probes();
    endtask

    // Paddle bot: up/down pair steering paddle centre toward ball centre
    function automatic logic [1:0] track(int top, int ballv);
        int c, b;
        c = top + PH / 2;
        b = ballv + BS / 2;
        if (c > b + 2) return 2'b01;
        if (c < b - 2) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        int nserve;
        int k;
        logic [1:0] tl, tr;

        model_reset();
        do_reset(1'b0);

        x = 10'd0; y = 10'd0; video_on = 1'b1; #1;
        check("rgb00_on", 32'(rgb), 32'h0CCC);
        video_on = 1'b0; #1;
        check("rgb00_off", 32'(rgb), 32'h0000);
        video_on = 1'b1;

        repeat (3) frame(2'b00, 2'b00, 1'b0);
        x = 10'd316; y = 10'd236; #1;
        check("ball_centre", 32'(rgb), 32'h01FF);
        x = 10'd315; #1;
        check("ball_centre_w", 32'(rgb), 32'h0CCC);
        x = 10'd1; y = 10'd0;

        nserve = 0;
        frame(2'b00, 2'b00, 1'b1);
        if (state == 3'd1) nserve++;
        repeat (69) begin
            frame(2'b00, 2'b00, 1'b0);
            if (state == 3'd1) nserve++;
        end
        check("serve_len", nserve, 60);

        repeat (250) begin
            tr = track(padr, by);
            frame({tr[0], 1'b0}, {tr[1], 1'b1}, 1'b0);
        end
        repeat (2) begin
            tr = track(padr, by);
            frame({tr[0], 1'b1}, {tr[1], 1'b1}, 1'b0);
        end

        repeat (300) begin
            tl = track(padl, by);
            tr = track(padr, by);
            frame({tr[0], tl[0]}, {tr[1], tl[1]}, 1'b0);
        end

        k = 0;
        while (gs != OVER && k < 20000) begin
            tl = track(padl, by);
            frame({1'($urandom), tl[0]}, {1'($urandom), tl[1]}, 1'b0);
            k++;
        end
        check("over_reached", 32'(state), OVER);

        repeat (5) frame(2'($urandom), 2'($urandom), 1'b0);
        frame(2'b00, 2'b00, 1'b1);
        check("restart_state", 32'(state), SERVE);
        check("restart_sl", 32'(score_l), 0);

        for (int i = 0; i < 600; i++) begin
            if (i == 200) do_reset(1'b0);
            else if (i == 400) do_reset(1'b1);
            else frame(2'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
